// File: rtl/lcd_spi_write.sv
// Serialises 9-bit {dc, payload} words into a mode-0 SPI stream (CS, DC, SCK, MOSI), MSB first.
// States: IDLE wait/latch | SETUP CS low, MSB driven | SHIFT 16 SCK half-periods | DONE wr_done pulse | GAP CS-high idle.
module lcd_spi_write #(
    parameter int HALF_PERIOD = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       sys_clk_50MHz,
    input  logic       sys_rst,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_cs,
    output logic       lcd_dc,
    output logic       lcd_sck,
    output logic       lcd_mosi
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE,
        S_GAP
    } state_t;

    localparam int              GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [7:0]      DIV_LAST = 8'(HALF_PERIOD - 1);
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic [3:0]    hp_q, hp_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    sh_q, sh_d;
    logic          dc_q, dc_d;
    logic          cs_q, cs_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          wr_done_q, wr_done_d;
    logic          busy_q, busy_d;
    logic [3:0]    hp_adv;
    logic [2:0]    bit_idx;

    // Odd half-periods present the next lower bit; the last one holds bit 0.
    always_comb begin
        hp_adv  = (hp_q == 4'd15) ? 4'd14 : hp_q + 4'd1;
        bit_idx = 3'd7 - hp_adv[3:1];
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        hp_d      = hp_q;
        gap_d     = gap_q;
        sh_d      = sh_q;
        dc_d      = dc_q;
        cs_d      = 1'b1;
        sck_d     = 1'b0;
        mosi_d    = mosi_q;
        wr_done_d = 1'b0;
        busy_d    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (en_write) begin
                    sh_d    = data[7:0];
                    dc_d    = data[8];
                    div_d   = '0;
                    hp_d    = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cs_d   = 1'b0;
                mosi_d = sh_q[7];
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_SHIFT: begin
                cs_d   = 1'b0;
                sck_d  = ~hp_q[0];
                mosi_d = sh_q[bit_idx];
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (hp_q == 4'd15) begin
                        hp_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        hp_d = hp_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_DONE: begin
                wr_done_d = 1'b1;
                gap_d     = GAP_LAST;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            hp_q      <= '0;
            gap_q     <= '0;
            sh_q      <= '0;
            dc_q      <= 1'b0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            wr_done_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            hp_q      <= hp_d;
            gap_q     <= gap_d;
            sh_q      <= sh_d;
            dc_q      <= dc_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            wr_done_q <= wr_done_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_done  = wr_done_q;
    assign busy     = busy_q;
    assign lcd_cs   = cs_q;
    assign lcd_dc   = dc_q;
    assign lcd_sck  = sck_q;
    assign lcd_mosi = mosi_q;
endmodule

// File: tb/tb_lcd_spi_write.sv
// Bench for lcd_spi_write: an SPI decoder feeds observed words to a queue that tests compare against pushed expectations.
module tb_lcd_spi_write;
    localparam int H = 2;
    localparam int G = 2;
    localparam int PERIOD = 17 * H + G + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [8:0] data = '0;
    logic       wr_done, busy, lcd_cs, lcd_dc, lcd_sck, lcd_mosi;

    always #10 clk = ~clk;

    lcd_spi_write #(.HALF_PERIOD(H), .GAP_CYCLES(G)) dut (
        .sys_clk_50MHz(clk),
        .sys_rst      (rst),
        .en_write     (en),
        .data         (data),
        .wr_done      (wr_done),
        .busy         (busy),
        .lcd_cs       (lcd_cs),
        .lcd_dc       (lcd_dc),
        .lcd_sck      (lcd_sck),
        .lcd_mosi     (lcd_mosi)
    );

    typedef struct {
        logic [8:0] word;
        int         edges;
        int         bits;
        int         cyc;
    } obs_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         wd_count = 0;
    logic       prev_cs = 1'b1;
    logic       prev_sck = 1'b0;
    logic [7:0] sh = '0;
    int         nbits = 0;
    int         nedges = 0;
    int         rise_q[$];
    int         csfall_q[$];
    obs_t       obs_q[$];
    logic [8:0] exp_q[$];

    // One clock; decode the SPI lines as the panel would see them.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_cs === 1'b1 && lcd_cs === 1'b0) begin
            nbits = 0;
            nedges = 0;
            sh = '0;
            csfall_q.push_back(cyc);
        end
        if (lcd_cs === 1'b0 && lcd_sck !== prev_sck) nedges++;
        if (lcd_cs === 1'b0 && prev_sck === 1'b0 && lcd_sck === 1'b1) begin
            sh = {sh[6:0], lcd_mosi};
            nbits++;
            rise_q.push_back(cyc);
        end
        if (wr_done === 1'b1) begin
            wd_count++;
            obs_q.push_back('{word: {lcd_dc, sh}, edges: nedges, bits: nbits, cyc: cyc});
        end
        prev_cs = lcd_cs;
        prev_sck = lcd_sck;
    endtask

    task automatic wait_done(input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (wr_done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        bit   to;
        obs_t o;
        logic [8:0] e;
        rst = 1'b1;
        en = 1'b1;
        data = 9'h011;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({lcd_cs, lcd_sck, lcd_mosi, lcd_dc, wr_done, busy} !== 6'b100000) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d got cs,sck,mosi,dc,done,busy=%b expected 100000", cyc,
                         {lcd_cs, lcd_sck, lcd_mosi, lcd_dc, wr_done, busy});
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (lcd_cs !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_latch_edge got cs=%b busy=%b expected cs=1 busy=0", lcd_cs, busy);
        end
        tick();
        n_cmp++;
        if (lcd_cs !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_latch got cs=%b busy=%b expected cs=0 busy=1", lcd_cs, busy);
        end
        en = 1'b0;
        exp_q.push_back(9'h011);
        wait_done(3 * PERIOD, to);
        n_cmp++;
        if (to || obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL reset_word_timeout got no wr_done expected one");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.word !== e) begin
                n_bad++;
                $display("FAIL reset_word got %h expected %h", o.word, e);
            end
        end
        exp_q.delete();
        idle_ticks(G + 2);
    endtask

    task automatic test_single_command();
        int   t0;
        int   n;
        obs_t o;
        exp_q.push_back(9'h011);
        en = 1'b1;
        data = 9'h011;
        tick();
        t0 = cyc;
        en = 1'b0;
        rise_q.delete();
        for (int i = 1; i <= PERIOD; i++) begin
            tick();
            n = cyc - t0;
            n_cmp++;
            if (lcd_cs !== ((n >= 1 && n <= 17 * H) ? 1'b0 : 1'b1)) begin
                n_bad++;
                $display("FAIL single_cs n=%0d got %b expected %b", n, lcd_cs, (n >= 1 && n <= 17 * H) ? 1'b0 : 1'b1);
            end
            n_cmp++;
            if (wr_done !== ((n == 1 + 17 * H) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL single_wr_done n=%0d got %b expected %b", n, wr_done, (n == 1 + 17 * H) ? 1'b1 : 1'b0);
            end
        end
        n_cmp++;
        if (rise_q.size() != 8) begin
            n_bad++;
            $display("FAIL single_rise_count got %0d expected 8", rise_q.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_cmp++;
                if (rise_q[j] - t0 != 1 + H + 2 * j * H) begin
                    n_bad++;
                    $display("FAIL single_rise_cycle bit=%0d got %0d expected %0d", j, rise_q[j] - t0, 1 + H + 2 * j * H);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("FAIL single_word_count got %0d expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o.word !== exp_q[0]) begin
                n_bad++;
                $display("FAIL single_word got %h expected %h", o.word, exp_q[0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        idle_ticks(2);
    endtask

    task automatic test_data_word();
        bit   to;
        obs_t o;
        logic [8:0] e;
        exp_q.push_back(9'h1A5);
        en = 1'b1;
        data = 9'h1A5;
        tick();
        en = 1'b0;
        idle_ticks(5);
        data = 9'h000;
        wait_done(3 * PERIOD, to);
        n_cmp++;
        if (to || obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL data_timeout got no wr_done expected one");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.word !== e) begin
                n_bad++;
                $display("FAIL data_word got %h expected %h", o.word, e);
            end
            n_cmp++;
            if (o.edges != 16 || o.bits != 8) begin
                n_bad++;
                $display("FAIL data_edges got edges=%0d bits=%0d expected edges=16 bits=8", o.edges, o.bits);
            end
        end
        idle_ticks(G + 2);
    endtask

    task automatic test_back_to_back();
        logic [8:0] words [4];
        int   idx;
        int   got;
        bit   pend;
        obs_t o;
        logic [8:0] e;
        words = '{9'h036, 9'h160, 9'h02a, 9'h100};
        for (int i = 0; i < 4; i++) exp_q.push_back(words[i]);
        obs_q.delete();
        csfall_q.delete();
        idx = 0;
        got = 0;
        pend = 1'b0;
        data = words[0];
        en = 1'b1;
        for (int i = 0; i < 6 * PERIOD && got < 4; i++) begin
            tick();
            if (pend) begin
                pend = 1'b0;
                if (idx < 4) data = words[idx];
            end
            if (wr_done === 1'b1) begin
                got++;
                idx++;
                pend = 1'b1;
                if (got == 4) en = 1'b0;
            end
        end
        en = 1'b0;
        n_cmp++;
        if (got != 4 || obs_q.size() != 4 || csfall_q.size() != 4) begin
            n_bad++;
            $display("FAIL b2b_count got done=%0d words=%0d starts=%0d expected 4", got, obs_q.size(), csfall_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                n_cmp++;
                if (o.word !== e) begin
                    n_bad++;
                    $display("FAIL b2b_word idx=%0d got %h expected %h", i, o.word, e);
                end
                n_cmp++;
                if (o.cyc - (csfall_q[i] - 1) != 1 + 17 * H) begin
                    n_bad++;
                    $display("FAIL b2b_done_latency idx=%0d got %0d expected %0d", i, o.cyc - (csfall_q[i] - 1), 1 + 17 * H);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (csfall_q[i] - csfall_q[i-1] != PERIOD) begin
                        n_bad++;
                        $display("FAIL b2b_period idx=%0d got %0d expected %0d", i, csfall_q[i] - csfall_q[i-1], PERIOD);
                    end
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
        idle_ticks(G + 2);
    endtask

    task automatic test_reset_mid_word();
        int   base;
        bit   to;
        obs_t o;
        logic [8:0] e;
        base = wd_count;
        en = 1'b1;
        data = 9'h1F0;
        tick();
        en = 1'b0;
        rise_q.delete();
        for (int i = 0; i < PERIOD && rise_q.size() < 4; i++) tick();
        n_cmp++;
        if (rise_q.size() != 4) begin
            n_bad++;
            $display("FAIL abort_rise_timeout got %0d rises expected 4", rise_q.size());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({lcd_cs, lcd_sck, lcd_mosi, lcd_dc, wr_done, busy} !== 6'b100000) begin
            n_bad++;
            $display("FAIL abort_outputs got cs,sck,mosi,dc,done,busy=%b expected 100000",
                     {lcd_cs, lcd_sck, lcd_mosi, lcd_dc, wr_done, busy});
        end
        idle_ticks(PERIOD);
        n_cmp++;
        if (wd_count != base || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL abort_no_done got %0d pulses expected 0", wd_count - base);
        end
        obs_q.delete();
        exp_q.push_back(9'h1C3);
        en = 1'b1;
        data = 9'h1C3;
        tick();
        en = 1'b0;
        wait_done(3 * PERIOD, to);
        n_cmp++;
        if (to || obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL abort_next_timeout got no wr_done expected one");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.word !== e || o.bits != 8) begin
                n_bad++;
                $display("FAIL abort_next_word got %h bits=%0d expected %h bits=8", o.word, o.bits, e);
            end
        end
        exp_q.delete();
        idle_ticks(G + 2);
    endtask

    task automatic test_withdrawal();
        int   base;
        bit   to;
        obs_t o;
        logic [8:0] e;
        obs_q.delete();
        base = wd_count;
        exp_q.push_back(9'h05A);
        en = 1'b1;
        data = 9'h05A;
        tick();
        idle_ticks(6);
        en = 1'b0;
        wait_done(3 * PERIOD, to);
        n_cmp++;
        if (to || obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL withdraw_timeout got no wr_done expected one");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.word !== e) begin
                n_bad++;
                $display("FAIL withdraw_word got %h expected %h", o.word, e);
            end
        end
        idle_ticks(PERIOD);
        n_cmp++;
        if (wd_count != base + 1 || lcd_cs !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL withdraw_idle got pulses=%0d cs=%b busy=%b expected pulses=1 cs=1 busy=0",
                     wd_count - base, lcd_cs, busy);
        end
        exp_q.delete();
        obs_q.delete();
        base = wd_count;
        exp_q.push_back(9'h1FF);
        en = 1'b1;
        data = 9'h1FF;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick();
            if (i == 3) en = 1'b0;
        end
        n_cmp++;
        if (wd_count != base + 1 || obs_q.size() != 1) begin
            n_bad++;
            $display("FAIL withdraw_resend_count got %0d pulses expected 1", wd_count - base);
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.word !== e) begin
                n_bad++;
                $display("FAIL withdraw_resend_word got %h expected %h", o.word, e);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_command();
        test_data_word();
        test_back_to_back();
        test_reset_mid_word();
        test_withdrawal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
